// File: rtl/byte_serial_feeder.sv
// rtl/byte_serial_feeder.sv - parallel byte to bit-serial strobe feeder for the serial-in byte queue
// Each bit is a write pulse of HIGH_CYCLES followed by a LOW_CYCLES gap; new bytes stall while the queue is full.
module byte_serial_feeder #(
  parameter int HIGH_CYCLES = 10,
  parameter int LOW_CYCLES  = 10,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic       clock1M,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       full_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [2:0] bit_idx
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_idx_q;
  logic          data_q;
  logic          write_q;
  logic          busy_q;

  logic [7:0]    src_d;
  logic [7:0]    shift_d;
  logic          bit_d;
  logic          accept;

  assign byte_ready = reset && (state_q == IDLE) && !full_in;
  assign accept     = byte_valid && byte_ready;

  // The first bit comes straight from byte_in; later bits from the remaining shift register.
  always_comb begin
    src_d   = (state_q == IDLE) ? byte_in : shreg_q;
    bit_d   = MSB_FIRST ? src_d[7] : src_d[0];
    shift_d = MSB_FIRST ? {src_d[6:0], 1'b0} : {1'b0, src_d[7:1]};
  end

  always_ff @(posedge clock1M) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobe trails the state by one cycle so data_out settles a full cycle before it rises.
      write_q <= (state_q == HIGH);
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= HIGH;
            cnt_q     <= HIGH_LOAD;
            bit_idx_q <= 3'd0;
            data_q    <= bit_d;
            shreg_q   <= shift_d;
            busy_q    <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            state_q <= LOW;
            cnt_q   <= LOW_LOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        LOW: begin
          if (cnt_q == '0) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              data_q  <= 1'b0;
            end else begin
              state_q   <= HIGH;
              cnt_q     <= HIGH_LOAD;
              bit_idx_q <= bit_idx_q + 3'd1;
              data_q    <= bit_d;
              shreg_q   <= shift_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign write_out = write_q;
  assign busy_out  = busy_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_byte_serial_feeder.sv
// tb/tb_byte_serial_feeder.sv - directed self-checking bench for byte_serial_feeder
// Instances: 0 = H=L=10 MSB first, 1 = H=L=10 LSB first, 2 = H=L=1 MSB first.
module tb_byte_serial_feeder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] bin  [3];
  logic       vld  [3];
  logic       full [3];
  logic       rdy  [3];
  logic       dout [3];
  logic       wout [3];
  logic       busy [3];
  logic [2:0] idx  [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_seq;
  int cap_pulses, cap_busy, cap_idle, cap_width_err, cap_gap_err, cap_stab_err, cap_idx_err, cap_lat;

  always #5 clk = ~clk;

  byte_serial_feeder #(.HIGH_CYCLES(10), .LOW_CYCLES(10), .MSB_FIRST(1'b1)) dut_a (
    .clock1M(clk), .reset(rstn), .byte_in(bin[0]), .byte_valid(vld[0]), .byte_ready(rdy[0]),
    .full_in(full[0]), .data_out(dout[0]), .write_out(wout[0]), .busy_out(busy[0]), .bit_idx(idx[0]));

  byte_serial_feeder #(.HIGH_CYCLES(10), .LOW_CYCLES(10), .MSB_FIRST(1'b0)) dut_b (
    .clock1M(clk), .reset(rstn), .byte_in(bin[1]), .byte_valid(vld[1]), .byte_ready(rdy[1]),
    .full_in(full[1]), .data_out(dout[1]), .write_out(wout[1]), .busy_out(busy[1]), .bit_idx(idx[1]));

  byte_serial_feeder #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .MSB_FIRST(1'b1)) dut_c (
    .clock1M(clk), .reset(rstn), .byte_in(bin[2]), .byte_valid(vld[2]), .byte_ready(rdy[2]),
    .full_in(full[2]), .data_out(dout[2]), .write_out(wout[2]), .busy_out(busy[2]), .bit_idx(idx[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; leaves the bench on the negedge right after the accepting edge.
  task automatic accept(input int d, input logic [7:0] b, input bit keep_valid);
    int w = 0;
    bin[d] = b;
    vld[d] = 1'b1;
    while (!rdy[d] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(rdy[d]), 32'd1);
    @(negedge clk);
    if (!keep_valid) vld[d] = 1'b0;
  endtask

  // Samples every negedge from the cycle after acceptance until n pulses are seen and busy drops.
  task automatic capture(input string tag, input int d, input int h, input int l, input int n);
    logic prev_w = 1'b0;
    logic prev_d = 1'b0;
    logic cur_bit = 1'b0;
    int hi = 0;
    int lo = 0;
    bit done = 1'b0;
    cap_seq = '0; cap_pulses = 0; cap_busy = 0; cap_idle = 0;
    cap_width_err = 0; cap_gap_err = 0; cap_stab_err = 0; cap_idx_err = 0; cap_lat = -1;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (busy[d]) cap_busy++;
      if (wout[d] && !prev_w) begin
        if (cap_pulses == 0) cap_lat = c;
        else if ((cap_pulses % 8) != 0 && lo != l) cap_gap_err++;
        if (dout[d] !== prev_d) cap_stab_err++;
        if (idx[d] !== 3'(cap_pulses % 8)) cap_idx_err++;
        cap_seq = {cap_seq[30:0], dout[d]};
        cur_bit = dout[d];
        hi = 0;
        cap_pulses++;
      end
      if (!wout[d] && prev_w) begin
        if (hi != h) cap_width_err++;
        lo = 0;
      end
      if (wout[d]) begin
        hi++;
        if (dout[d] !== cur_bit) cap_stab_err++;
      end else begin
        lo++;
      end
      if (!busy[d] && cap_pulses >= n) done = 1'b1;
      else if (!busy[d]) cap_idle++;
      if (!done) begin
        prev_w = wout[d];
        prev_d = dout[d];
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_run(input string tag, input logic [31:0] seq, input int pulses, input int busy_n);
    check({tag, "_seq"}, cap_seq, seq);
    check({tag, "_pulses"}, 32'(cap_pulses), 32'(pulses));
    check({tag, "_busy"}, 32'(cap_busy), 32'(busy_n));
    check({tag, "_width"}, 32'(cap_width_err), 32'd0);
    check({tag, "_gap"}, 32'(cap_gap_err), 32'd0);
    check({tag, "_stable"}, 32'(cap_stab_err), 32'd0);
    check({tag, "_idx"}, 32'(cap_idx_err), 32'd0);
    check({tag, "_lat"}, 32'(cap_lat), 32'd1);
  endtask

  initial begin
    int bp_err;
    int r;
    logic pw;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bin[i] = 8'h00; vld[i] = 1'b0; full[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rdy[0]), 32'd0);
    check("rst_data", 32'(dout[0]), 32'd0);
    check("rst_write", 32'(wout[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_idx", 32'(idx[0]), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(rdy[0]), 32'd1);

    // Single byte 0xA5, MSB first: 1,0,1,0,0,1,0,1.
    accept(0, 8'hA5, 1'b0);
    capture("a5", 0, 10, 10, 8);
    check_run("a5", 32'h0000_00A5, 8, 160);
    check("a5_ready_after", 32'(rdy[0]), 32'd1);

    // 0x32 LSB first sends 0,1,0,0,1,1,0,0 -> collected 0x4C.
    accept(1, 8'h32, 1'b0);
    capture("lsb32", 1, 10, 10, 8);
    check_run("lsb32", 32'h0000_004C, 8, 160);
    accept(0, 8'h32, 1'b0);
    capture("msb32", 0, 10, 10, 8);
    check_run("msb32", 32'h0000_0032, 8, 160);

    // Back-to-back with byte_valid held.
    accept(0, 8'h3C, 1'b1);
    bin[0] = 8'h01;
    capture("b2b", 0, 10, 10, 16);
    vld[0] = 1'b0;
    check_run("b2b", 32'h0000_3C01, 16, 320);
    check("b2b_idle", 32'(cap_idle), 32'd1);

    // Backpressure, then full raised mid-byte.
    full[0] = 1'b1;
    bin[0] = 8'h5A;
    vld[0] = 1'b1;
    bp_err = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy[0] || wout[0] || busy[0]) bp_err++;
    end
    check("bp_stall", 32'(bp_err), 32'd0);
    full[0] = 1'b0;
    @(negedge clk);
    check("bp_accept", 32'(busy[0]), 32'd1);
    vld[0] = 1'b0;
    fork
      capture("bp", 0, 10, 10, 8);
      begin
        repeat (40) @(negedge clk);
        full[0] = 1'b1;
      end
    join
    check_run("bp", 32'h0000_005A, 8, 160);
    check("bp_ready_full", 32'(rdy[0]), 32'd0);
    full[0] = 1'b0;

    // Reset during the 4th pulse.
    accept(0, 8'h5A, 1'b0);
    r = 0;
    pw = 1'b0;
    for (int i = 0; i < 500 && r < 4; i++) begin
      if (wout[0] && !pw) r++;
      pw = wout[0];
      if (r < 4) @(negedge clk);
    end
    check("mid_pulse4", 32'(r), 32'd4);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_write", 32'(wout[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_idx", 32'(idx[0]), 32'd0);
    check("mid_rst_data", 32'(dout[0]), 32'd0);
    check("mid_rst_ready", 32'(rdy[0]), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    accept(0, 8'hFF, 1'b0);
    capture("ff", 0, 10, 10, 8);
    check_run("ff", 32'h0000_00FF, 8, 160);

    // Minimum timing H=L=1.
    accept(2, 8'h80, 1'b0);
    capture("min", 2, 1, 1, 8);
    check_run("min", 32'h0000_0080, 8, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
